// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter and its ALU.
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD   = 2'b00;
    localparam alu_op_t ALU_SUB   = 2'b01;
    localparam alu_op_t ALU_PASSA = 2'b10;
    localparam alu_op_t ALU_XOR   = 2'b11;

    localparam int unsigned FLG_V = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    typedef enum logic {OPEN, LOCKED} lock_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/pass-A/xor with [V,C,N,Z] flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned BITS = 64
) (
    input  alu_op_t         op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] result,
    output logic [3:0]      flags
);

    logic            is_sub;
    logic [BITS-1:0] b_eff;
    logic [BITS:0]   sum;

    // Subtraction is A + ~B + 1, so C=1 means "no borrow".
    always_comb begin
        is_sub = (op == ALU_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{BITS{1'b0}}, is_sub};
        result = '0;
        flags  = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result       = sum[BITS-1:0];
                flags[FLG_C] = sum[BITS];
                flags[FLG_V] = (a[BITS-1] == b_eff[BITS-1]) && (result[BITS-1] != a[BITS-1]);
            end
            ALU_PASSA: result = a;
            ALU_XOR:   result = a ^ b;
        endcase
        flags[FLG_N] = result[BITS-1];
        flags[FLG_Z] = (result == '0);
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first requester at or after Ptr (mod NREQ) wins.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] Req,
    input  logic [IDW-1:0]  Ptr,
    output logic [NREQ-1:0] Gnt,
    output logic [IDW-1:0]  GntIdx
);

    logic            found;
    int unsigned     idx;
    logic [IDW-1:0]  sel;

    always_comb begin
        Gnt    = '0;
        GntIdx = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = 32'(Ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IDW'(idx);
            if (!found && Req[sel]) begin
                found    = 1'b1;
                Gnt[sel] = 1'b1;
                GntIdx   = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a grant lock
// for back-to-back ops and a registered, handshaked result carrying the issuer ID.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned BITS = 64,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    ReqValid,
    input  logic [NREQ-1:0]    ReqLock,
    input  logic [2*NREQ-1:0]  ReqOp,
    input  logic [BITS*NREQ-1:0] ReqSrcA,
    input  logic [BITS*NREQ-1:0] ReqSrcB,
    output logic [NREQ-1:0]    ReqReady,
    output logic               RespValid,
    input  logic               RespReady,
    output logic [IDW-1:0]     RespId,
    output logic [BITS-1:0]    RespResult,
    output logic [3:0]         RespFlags,
    output logic               Locked
);

    lock_state_t     state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  ptr_next;
    logic            can_issue;
    logic            accept;

    alu_op_t         op;
    logic [BITS-1:0] src_a;
    logic [BITS-1:0] src_b;
    logic [BITS-1:0] alu_res;
    logic [3:0]      alu_flags;

    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    // While locked, masking the request vector down to the owner lets the
    // shared picker produce the grant in both states.
    always_comb begin
        owner_onehot = NREQ'(1) << owner;
        eligible     = (state == LOCKED) ? (ReqValid & owner_onehot) : ReqValid;
        can_issue    = !RespValid || RespReady;
        ReqReady     = (rst_n && can_issue) ? gnt : '0;
        accept       = |ReqReady;
        ptr_next     = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .Req    (eligible),
        .Ptr    (ptr),
        .Gnt    (gnt),
        .GntIdx (gnt_idx)
    );

    always_comb begin
        op    = ALU_ADD;
        src_a = '0;
        src_b = '0;
        if (|gnt) begin
            op    = alu_op_t'(ReqOp[2*gnt_idx +: 2]);
            src_a = ReqSrcA[BITS*gnt_idx +: BITS];
            src_b = ReqSrcB[BITS*gnt_idx +: BITS];
        end
    end

    alu #(
        .BITS (BITS)
    ) u_alu (
        .op     (op),
        .a      (src_a),
        .b      (src_b),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RespValid  <= 1'b0;
            RespId     <= '0;
            RespResult <= '0;
            RespFlags  <= '0;
            ptr        <= '0;
            owner      <= '0;
            state      <= OPEN;
            Locked     <= 1'b0;
        end else begin
            if (accept) begin
                RespValid  <= 1'b1;
                RespId     <= gnt_idx;
                RespResult <= alu_res;
                RespFlags  <= alu_flags;
                ptr        <= ptr_next;
            end else if (RespReady) begin
                RespValid  <= 1'b0;
            end

            case (state)
                OPEN: begin
                    if (accept && ReqLock[gnt_idx]) begin
                        state  <= LOCKED;
                        owner  <= gnt_idx;
                        Locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Only the owner can be accepted here, so accept implies owner.
                    if (!ReqLock[owner] && (accept || !ReqValid[owner])) begin
                        state  <= OPEN;
                        Locked <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard testbench for alu_arbiter: expected results queued on issue, compared on drain.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned BITS = 64;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        ReqValid;
    logic [NREQ-1:0]        ReqLock;
    logic [2*NREQ-1:0]      ReqOp;
    logic [BITS*NREQ-1:0]   ReqSrcA;
    logic [BITS*NREQ-1:0]   ReqSrcB;
    logic [NREQ-1:0]        ReqReady;
    logic                   RespValid;
    logic                   RespReady;
    logic [IDW-1:0]         RespId;
    logic [BITS-1:0]        RespResult;
    logic [3:0]             RespFlags;
    logic                   Locked;

    always #5 clk = ~clk;

    alu_arbiter #(
        .BITS (BITS),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ReqValid   (ReqValid),
        .ReqLock    (ReqLock),
        .ReqOp      (ReqOp),
        .ReqSrcA    (ReqSrcA),
        .ReqSrcB    (ReqSrcB),
        .ReqReady   (ReqReady),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespId     (RespId),
        .RespResult (RespResult),
        .RespFlags  (RespFlags),
        .Locked     (Locked)
    );

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [BITS-1:0] res;
        logic [3:0]      flags;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_ptr = 0;

    // Reference ALU: carry from unsigned compares, overflow from exact wide arithmetic.
    function automatic exp_t model(int unsigned id, alu_op_t op, logic [BITS-1:0] a, logic [BITS-1:0] b);
        exp_t                   e;
        logic signed [BITS+1:0] sa, sbv, s;
        logic [BITS-1:0]        r;
        logic                   c, v;
        sa  = $signed({{2{a[BITS-1]}}, a});
        sbv = $signed({{2{b[BITS-1]}}, b});
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            ALU_ADD:   begin r = a + b; c = (r < a);  s = sa + sbv; v = (s != $signed({{2{r[BITS-1]}}, r})); end
            ALU_SUB:   begin r = a - b; c = (a >= b); s = sa - sbv; v = (s != $signed({{2{r[BITS-1]}}, r})); end
            ALU_PASSA: r = a;
            default:   r = a ^ b;
        endcase
        e.id    = IDW'(id);
        e.res   = r;
        e.flags = {v, c, r[BITS-1], (r == '0)};
        return e;
    endfunction

    task automatic drive(int unsigned i, alu_op_t op, logic [BITS-1:0] a, logic [BITS-1:0] b);
        ReqOp[2*i +: 2]      = op;
        ReqSrcA[BITS*i +: BITS] = a;
        ReqSrcB[BITS*i +: BITS] = b;
    endtask

    task automatic expect_op(int unsigned id, alu_op_t op, logic [BITS-1:0] a, logic [BITS-1:0] b);
        sb.push_back(model(id, op, a, b));
        exp_ptr = (id + 1) % NREQ;
    endtask

    function automatic logic [NREQ-1:0] onehot(int unsigned g);
        logic [NREQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Drains the scoreboard on each handshake just before the edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (RespValid && RespReady) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_drain: got unexpected id=%0d result=%h, required no result", RespId, RespResult);
            end else begin
                e = sb.pop_front();
                if (RespId !== e.id || RespResult !== e.res || RespFlags !== e.flags) begin
                    n_fail++;
                    $display("FAIL sb_drain: got id=%0d result=%h flags=%b, required id=%0d result=%h flags=%b",
                             RespId, RespResult, RespFlags, e.id, e.res, e.flags);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; RespReady = 1'b1;
        ReqValid = '1; ReqLock = '1; ReqOp = '0; ReqSrcA = '0; ReqSrcB = '0;
        #12;
        n_tests++;
        if (ReqReady !== '0 || RespValid !== 1'b0 || Locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b locked=%b, required 0000/0/0", ReqReady, RespValid, Locked);
        end
        n_tests++;
        if (RespId !== '0 || RespResult !== '0 || RespFlags !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got id=%0d result=%h flags=%b, required zeros", RespId, RespResult, RespFlags);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; ReqValid = '0; ReqLock = '0;
        exp_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op();
        drive(0, ALU_ADD, 64'd5, 64'd7);
        ReqValid = 4'b0001;
        #1;
        n_tests++;
        if (ReqReady !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b, required 0001", ReqReady);
        end
        expect_op(0, ALU_ADD, 64'd5, 64'd7);
        tick();
        ReqValid = '0;
        n_tests++;
        if (RespValid !== 1'b1 || RespId !== 2'd0 || RespResult !== 64'd12 || RespFlags !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_resp: got v=%b id=%0d res=%0d flags=%b, required 1/0/12/0000",
                     RespValid, RespId, RespResult, RespFlags);
        end
        tick();
        n_tests++;
        if (RespValid !== 1'b0) begin
            n_fail++; $display("FAIL single_clear: got RespValid=%b, required 0", RespValid);
        end
    endtask

    task automatic test_round_robin();
        logic [BITS-1:0] a[NREQ];
        logic [BITS-1:0] b[NREQ];
        int unsigned g;
        for (int k = 0; k < 5; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                a[i] = {$urandom, $urandom};
                b[i] = {$urandom, $urandom};
                drive(i, ALU_XOR, a[i], b[i]);
            end
            ReqValid = '1;
            #1;
            g = exp_ptr;
            n_tests++;
            if (ReqReady !== onehot(g)) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b, required %b", k, ReqReady, onehot(g));
            end
            expect_op(g, ALU_XOR, a[g], b[g]);
            tick();
            n_tests++;
            if (RespValid !== 1'b1) begin
                n_fail++; $display("FAIL rr_valid[%0d]: got %b, required 1", k, RespValid);
            end
        end
        ReqValid = '0;
        tick();
    endtask

    task automatic test_lock();
        logic [127:0] key;
        key = {$urandom, $urandom, $urandom, $urandom};
        drive(1, ALU_ADD, 64'h11, 64'h22);
        drive(2, ALU_XOR, key[127:64], 64'hA5A5_A5A5_5A5A_5A5A);
        ReqValid = 4'b0110; ReqLock = 4'b0100;
        #1;
        n_tests++;
        if (ReqReady !== 4'b0100) begin
            n_fail++; $display("FAIL lock_first: got %b, required 0100", ReqReady);
        end
        expect_op(2, ALU_XOR, key[127:64], 64'hA5A5_A5A5_5A5A_5A5A);
        tick();
        n_tests++;
        if (Locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_set: got Locked=%b, required 1", Locked);
        end
        ReqLock = 4'b0000;
        drive(2, ALU_XOR, key[63:0], 64'h0F0F_F0F0_0F0F_F0F0);
        #1;
        n_tests++;
        if (ReqReady !== 4'b0100) begin
            n_fail++; $display("FAIL lock_second: got %b, required 0100", ReqReady);
        end
        expect_op(2, ALU_XOR, key[63:0], 64'h0F0F_F0F0_0F0F_F0F0);
        tick();
        ReqValid = 4'b0010;
        #1;
        n_tests++;
        if (Locked !== 1'b0 || ReqReady !== 4'b0010) begin
            n_fail++; $display("FAIL lock_release: got locked=%b ready=%b, required 0/0010", Locked, ReqReady);
        end
        expect_op(1, ALU_ADD, 64'h11, 64'h22);
        tick();
        // Owner holds the lock while idle, then drops it without issuing.
        drive(3, ALU_PASSA, 64'hDEAD_BEEF, 64'h0);
        ReqValid = 4'b1000; ReqLock = 4'b1000;
        #1;
        n_tests++;
        if (ReqReady !== 4'b1000) begin
            n_fail++; $display("FAIL lock3_ready: got %b, required 1000", ReqReady);
        end
        expect_op(3, ALU_PASSA, 64'hDEAD_BEEF, 64'h0);
        tick();
        drive(0, ALU_SUB, 64'd100, 64'd1);
        ReqValid = 4'b0001;
        #1;
        n_tests++;
        if (ReqReady !== 4'b0000 || Locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_idle_hold: got ready=%b locked=%b, required 0000/1", ReqReady, Locked);
        end
        tick();
        ReqLock = 4'b0000;
        #1;
        n_tests++;
        if (ReqReady !== 4'b0000 || Locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_drop_cycle: got ready=%b locked=%b, required 0000/1", ReqReady, Locked);
        end
        tick();
        n_tests++;
        if (ReqReady !== 4'b0001 || Locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_dropped: got ready=%b locked=%b, required 0001/0", ReqReady, Locked);
        end
        expect_op(0, ALU_SUB, 64'd100, 64'd1);
        tick();
        ReqValid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t hold;
        int unsigned g;
        logic [BITS-1:0] a[NREQ];
        for (int unsigned i = 0; i < NREQ; i++) begin
            a[i] = {$urandom, $urandom};
            drive(i, ALU_PASSA, a[i], 64'h0);
        end
        ReqValid = '1;
        #1;
        g = exp_ptr;
        hold = model(g, ALU_PASSA, a[g], 64'h0);
        n_tests++;
        if (ReqReady !== onehot(g)) begin
            n_fail++; $display("FAIL bp_first: got %b, required %b", ReqReady, onehot(g));
        end
        expect_op(g, ALU_PASSA, a[g], 64'h0);
        tick();
        RespReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                a[i] = {$urandom, $urandom};
                drive(i, ALU_PASSA, a[i], 64'h0);
            end
            #1;
            n_tests++;
            if (ReqReady !== '0 || RespValid !== 1'b1 || RespId !== hold.id || RespResult !== hold.res) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got ready=%b v=%b id=%0d res=%h, required 0000/1/%0d/%h",
                         k, ReqReady, RespValid, RespId, RespResult, hold.id, hold.res);
            end
            tick();
        end
        RespReady = 1'b1;
        #1;
        g = exp_ptr;
        n_tests++;
        if (ReqReady !== onehot(g)) begin
            n_fail++; $display("FAIL bp_resume: got %b, required %b", ReqReady, onehot(g));
        end
        expect_op(g, ALU_PASSA, a[g], 64'h0);
        tick();
        n_tests++;
        if (RespValid !== 1'b1) begin
            n_fail++; $display("FAIL bp_continuous: got RespValid=%b, required 1", RespValid);
        end
        ReqValid = '0;
        tick();
    endtask

    task automatic test_flags();
        alu_op_t         ops[5]   = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_XOR};
        logic [BITS-1:0] as[5]    = '{64'd3, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        logic [BITS-1:0] bs[5]    = '{64'd3, 64'd1, 64'd1, 64'd1, 64'h1234};
        logic [BITS-1:0] res[5]   = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        logic [3:0]      flg[5]   = '{4'b0101, 4'b0010, 4'b1010, 4'b0101, 4'b0001};
        ReqValid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            drive(0, ops[k], as[k], bs[k]);
            #1;
            expect_op(0, ops[k], as[k], bs[k]);
            tick();
            n_tests++;
            if (RespResult !== res[k] || RespFlags !== flg[k]) begin
                n_fail++;
                $display("FAIL flags[%0d]: got res=%h flags=%b, required res=%h flags=%b",
                         k, RespResult, RespFlags, res[k], flg[k]);
            end
        end
        ReqValid = '0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [BITS-1:0] a;
        drive(1, ALU_ADD, 64'd40, 64'd2);
        ReqValid = 4'b0010; ReqLock = 4'b0010;
        #1;
        expect_op(1, ALU_ADD, 64'd40, 64'd2);
        tick();
        n_tests++;
        if (RespValid !== 1'b1 || Locked !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre: got v=%b locked=%b, required 1/1", RespValid, Locked);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (RespValid !== 1'b0 || Locked !== 1'b0 || ReqReady !== '0) begin
            n_fail++; $display("FAIL ar_async: got v=%b locked=%b ready=%b, required 0/0/0000", RespValid, Locked, ReqReady);
        end
        sb.delete();
        ReqValid = '0; ReqLock = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ptr = 0;
        a = {$urandom, $urandom};
        for (int unsigned i = 0; i < NREQ; i++) drive(i, ALU_XOR, a, 64'(i + 1));
        ReqValid = '1;
        #1;
        n_tests++;
        if (ReqReady !== 4'b0001) begin
            n_fail++; $display("FAIL ar_regrant: got %b, required 0001", ReqReady);
        end
        expect_op(0, ALU_XOR, a, 64'd1);
        tick();
        ReqValid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_flags();
        test_async_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one Alu instance (BITS-wide; ops add/sub/pass-A/xor; flags [V,C,N,Z]) among NREQ requesters, e.g. the SIMD lanes' AddRoundKey/key-schedule units.
- Arbitration is round-robin with a per-requester valid/ready handshake.
- A lock lets a requester issue back-to-back ops, e.g. two 64-bit halves of a 128-bit AES state.
- Results are registered and returned with the requester ID under a valid/ready handshake.

Parameters:
- BITS, 64, ALU operand/result width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ), minimum 1

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ReqValid  in  NREQ  per-requester operation valid
- ReqLock  in  NREQ  requester keeps grant after its accepted op
- ReqOp  in  2*NREQ  ALUControl per requester, slice i = [2i+1:2i]
- ReqSrcA  in  BITS*NREQ  operand A per requester, slice i = [BITS*i+BITS-1:BITS*i]
- ReqSrcB  in  BITS*NREQ  operand B, same slicing
- ReqReady  out  NREQ  one-hot or zero; op i accepted when ReqValid[i] && ReqReady[i]
- RespValid  out  1  result register holds a valid result
- RespReady  in  1  consumer accepts result
- RespId  out  IDW  index of requester that issued the result
- RespResult  out  BITS  registered ALUResult
- RespFlags  out  4  registered ALUFlags [V,C,N,Z]
- Locked  out  1  lock state active (debug/status)

Behaviour:
- Reset (async, rst_n=0): RespValid=0, RespId=0, RespResult=0, RespFlags=0, Locked=0, round-robin pointer Ptr=0, LockOwner=0, state OPEN. ReqReady=0 while rst_n=0.
- Can issue: CanIssue = !RespValid || RespReady.
- Grant in OPEN: the first i with ReqValid[i]=1, scanning Ptr, Ptr+1, ... mod NREQ. ReqReady[i]=CanIssue for that i only. ReqReady is combinational from ReqValid, state, Ptr, RespValid and RespReady.
- Grant in LOCKED: only LockOwner is eligible. ReqReady[LockOwner]=CanIssue && ReqValid[LockOwner]. All other requesters see 0.
- Datapath: the Alu is fed combinationally by the granted requester's ReqOp, ReqSrcA and ReqSrcB. With no grant, operands are 0 and the op is 00.
- Issue (accept of requester g): on the next edge, RespResult/RespFlags capture the Alu outputs, RespId=g, RespValid=1.
  - Latency: 1 cycle from accept to RespValid.
  - Throughput: 1 op/cycle while RespReady=1.
- Output register: when RespValid && RespReady with no new accept, RespValid clears next edge. Accept and drain in the same cycle: the register reloads and RespValid stays 1.
- Backpressure: while RespValid && !RespReady, all ReqReady=0 and the output register is held stable (Result, Flags, Id unchanged).
- Pointer: after an accept of g, Ptr = (g+1) mod NREQ. With no accept, Ptr is unchanged.
- Lock FSM, OPEN -> LOCKED: on an accept of g with ReqLock[g]=1; LockOwner=g.
- Lock FSM, LOCKED -> OPEN (either condition):
  - an accept by LockOwner with ReqLock[LockOwner]=0, which is its final op; or
  - ReqLock[LockOwner]=0 sampled while ReqValid[LockOwner]=0, which drops the lock in 1 cycle with no op.
- Lock and pointer: Ptr still advances past the owner on every owner accept, so the next OPEN arbitration starts after the owner.
- Locked = (state==LOCKED).
- ID wrap: when NREQ is not a power of two, only indices < NREQ are ever granted. The pointer wraps NREQ-1 -> 0.
- Simultaneous requests: exactly one grant per cycle. ReqReady is never multi-hot.
- Reset mid-operation: the pending result is discarded, RespValid drops asynchronously, and the lock is released.
- Arithmetic: entirely inside Alu (two's complement, flags as Alu defines). The arbiter adds no width change.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t (2-bit);
  - constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_PASSA=2'b10, ALU_XOR=2'b11;
  - flag index constants FLG_V=3, FLG_C=2, FLG_N=1, FLG_Z=0;
  - lock-state enum {OPEN, LOCKED}.
- Sub-module rr_picker (combinational, parameter NREQ): inputs Req[NREQ] and Ptr; outputs Gnt (one-hot) and GntIdx. Reusable by other shared-unit arbiters.
- The Alu is instantiated once inside alu_arbiter.

Test Plan:
1. Single op: ReqValid=0001, ReqOp[0]=00, A=5, B=7, RespReady=1 -> ReqReady=0001 same cycle; next cycle RespValid=1, RespId=0, RespResult=12, RespFlags=0000.
2. Round-robin fairness: ReqValid=1111 held, all XOR ops, RespReady=1 -> RespId sequence 0,1,2,3,0; one result/cycle; Ptr wraps 3->0.
3. Lock burst:
   - Stimulus: requester 2 and requester 1 both valid; requester 2 has ReqLock=1 for the first op and 0 for the second; both XOR with the halves of a 128-bit key.
   - Response: RespId sequence 2,2,1; Locked=1 between the two ops of requester 2; ReqReady[1]=0 while locked.
4. Backpressure: result pending, RespReady=0 for 3 cycles with ReqValid=1111 -> ReqReady=0000, RespResult/RespId stable. RespReady=1 -> same-cycle accept, new result next edge, RespValid continuous.
5. Flags through arbiter:
   - SUB A=3, B=3 -> RespFlags Z=1, C=1.
   - SUB A=0, B=1 -> RespResult=64'hFFFF_FFFF_FFFF_FFFF, N=1.
6. Async reset: assert rst_n=0 mid-cycle while RespValid=1 and LOCKED -> RespValid=0, Locked=0 immediately. After release, the next grant starts from requester 0.
